// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite crossbar.
//   RESP_OKAY / RESP_DECERR : AXI response codes used by the crossbar
//   xbar_state_e            : crossbar transaction state
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RD_ERR = 3'd3,
    WR_ERR = 3'd4
  } xbar_state_e;
endpackage

// File: rtl/ysyx_25010008_xbar_arb.sv
// Master arbiter for the AXI4-Lite crossbar.
//   clk, rst  : clock, asynchronous active-low reset
//   req       : per-master request vector
//   adv       : a transaction completed this cycle
//   adv_idx   : index of the master that completed
//   gnt       : one-hot grant (all zero when nobody requests)
//   gnt_idx   : index of the granted master
// Build option AXIL_XBAR_RR_EN: round-robin starting at rr_ptr; otherwise
// fixed priority with the lowest index winning and no pointer state.
module ysyx_25010008_xbar_arb #(
  parameter int NUM_M = 2,
  parameter int MW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req,
  input  logic             adv,
  input  logic [MW-1:0]    adv_idx,
  output logic [NUM_M-1:0] gnt,
  output logic [MW-1:0]    gnt_idx
);

`ifdef AXIL_XBAR_RR_EN
  logic [MW-1:0] rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv) rr_ptr_d = (adv_idx == MW'(NUM_M - 1)) ? '0 : adv_idx + 1'b1;
  end

  // Walk the masters starting at rr_ptr; the first requester found wins.
  always_comb begin
    logic [MW-1:0] c;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = '0;
    for (int k = 0; k < NUM_M; k++) begin
      c = MW'((int'(rr_ptr_q) + k) % NUM_M);
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = c;
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, adv, adv_idx};

  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = MW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ysyx_25010008_axil_xbar.sv
// AXI4-Lite crossbar: NUM_M masters to NUM_S slaves, one transaction in flight.
//   clk, rst          : clock, asynchronous active-low reset
//   m_ar*/m_r*        : master-side read address / read data channels
//   m_aw*/m_w*/m_b*   : master-side write address / data / response channels
//   s_*               : slave-side mirror of every m_* channel
//   S_BASE / S_MASK   : packed per-slave address map, slave 0 in the low bits
// Unmapped addresses are answered locally with DECERR.
// Build option AXIL_XBAR_RR_EN selects round-robin master arbitration.
module ysyx_25010008_axil_xbar
  import axil_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int NUM_S = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter logic [NUM_S*AW-1:0] S_BASE = {32'h1000_0000, 32'h8000_0000},
  parameter logic [NUM_S*AW-1:0] S_MASK = {32'hFFFF_F000, 32'hFF00_0000}
) (
  input  logic                  clk,
  input  logic                  rst,
  // master side
  input  logic [NUM_M*AW-1:0]   m_araddr,
  input  logic [NUM_M-1:0]      m_arvalid,
  output logic [NUM_M-1:0]      m_arready,
  output logic [NUM_M*DW-1:0]   m_rdata,
  output logic [NUM_M*2-1:0]    m_rresp,
  output logic [NUM_M-1:0]      m_rvalid,
  input  logic [NUM_M-1:0]      m_rready,
  input  logic [NUM_M*AW-1:0]   m_awaddr,
  input  logic [NUM_M-1:0]      m_awvalid,
  output logic [NUM_M-1:0]      m_awready,
  input  logic [NUM_M*DW-1:0]   m_wdata,
  input  logic [NUM_M*DW/8-1:0] m_wstrb,
  input  logic [NUM_M-1:0]      m_wvalid,
  output logic [NUM_M-1:0]      m_wready,
  output logic [NUM_M*2-1:0]    m_bresp,
  output logic [NUM_M-1:0]      m_bvalid,
  input  logic [NUM_M-1:0]      m_bready,
  // slave side
  output logic [NUM_S*AW-1:0]   s_araddr,
  output logic [NUM_S-1:0]      s_arvalid,
  input  logic [NUM_S-1:0]      s_arready,
  input  logic [NUM_S*DW-1:0]   s_rdata,
  input  logic [NUM_S*2-1:0]    s_rresp,
  input  logic [NUM_S-1:0]      s_rvalid,
  output logic [NUM_S-1:0]      s_rready,
  output logic [NUM_S*AW-1:0]   s_awaddr,
  output logic [NUM_S-1:0]      s_awvalid,
  input  logic [NUM_S-1:0]      s_awready,
  output logic [NUM_S*DW-1:0]   s_wdata,
  output logic [NUM_S*DW/8-1:0] s_wstrb,
  output logic [NUM_S-1:0]      s_wvalid,
  input  logic [NUM_S-1:0]      s_wready,
  input  logic [NUM_S*2-1:0]    s_bresp,
  input  logic [NUM_S-1:0]      s_bvalid,
  output logic [NUM_S-1:0]      s_bready
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int BW = DW / 8;

  // Per-port views of the flat buses.
  logic [NUM_M-1:0][AW-1:0] m_araddr_v, m_awaddr_v;
  logic [NUM_M-1:0][DW-1:0] m_wdata_v, m_rdata_o;
  logic [NUM_M-1:0][BW-1:0] m_wstrb_v;
  logic [NUM_M-1:0][1:0]    m_rresp_o, m_bresp_o;
  logic [NUM_S-1:0][DW-1:0] s_rdata_v, s_wdata_o;
  logic [NUM_S-1:0][1:0]    s_rresp_v, s_bresp_v;
  logic [NUM_S-1:0][AW-1:0] s_araddr_o, s_awaddr_o;
  logic [NUM_S-1:0][BW-1:0] s_wstrb_o;

  assign m_araddr_v = m_araddr;
  assign m_awaddr_v = m_awaddr;
  assign m_wdata_v  = m_wdata;
  assign m_wstrb_v  = m_wstrb;
  assign s_rdata_v  = s_rdata;
  assign s_rresp_v  = s_rresp;
  assign s_bresp_v  = s_bresp;
  assign m_rdata    = m_rdata_o;
  assign m_rresp    = m_rresp_o;
  assign m_bresp    = m_bresp_o;
  assign s_araddr   = s_araddr_o;
  assign s_awaddr   = s_awaddr_o;
  assign s_wdata    = s_wdata_o;
  assign s_wstrb    = s_wstrb_o;

  xbar_state_e   state_q, state_d;
  logic [MW-1:0] gnt_m_q, gnt_m_d;
  logic [SW-1:0] gnt_s_q, gnt_s_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  // Arbitration
  logic [NUM_M-1:0] arb_req, arb_gnt;
  logic [MW-1:0]    arb_idx;
  logic             arb_adv;

  assign arb_req = m_arvalid | m_awvalid;

  ysyx_25010008_xbar_arb #(.NUM_M(NUM_M), .MW(MW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .adv     (arb_adv),
    .adv_idx (gnt_m_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Address decode of the candidate master; a pending read beats a write.
  logic          is_rd;
  logic [AW-1:0] dec_addr;
  logic [NUM_S-1:0] hit;
  logic [SW-1:0] hit_idx;

  assign is_rd    = m_arvalid[arb_idx];
  assign dec_addr = is_rd ? m_araddr_v[arb_idx] : m_awaddr_v[arb_idx];

  for (genvar j = 0; j < NUM_S; j++) begin : g_dec
    assign hit[j] = (dec_addr & S_MASK[j*AW +: AW]) == S_BASE[j*AW +: AW];
  end

  always_comb begin
    hit_idx = '0;
    for (int j = NUM_S - 1; j >= 0; j--) begin
      if (hit[j]) hit_idx = SW'(j);
    end
  end

  // Transaction FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_m_q   <= '0;
      gnt_s_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_m_q   <= gnt_m_d;
      gnt_s_q   <= gnt_s_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_m_d   = gnt_m_q;
    gnt_s_d   = gnt_s_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arb_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          gnt_m_d = arb_idx;
          gnt_s_d = hit_idx;
          if (is_rd) state_d = (|hit) ? RD : RD_ERR;
          else       state_d = (|hit) ? WR : WR_ERR;
        end
      end
      RD: begin
        if (s_rvalid[gnt_s_q] && m_rready[gnt_m_q]) begin
          state_d = IDLE;
          arb_adv = 1'b1;
        end
      end
      WR: begin
        if (s_bvalid[gnt_s_q] && m_bready[gnt_m_q]) begin
          state_d = IDLE;
          arb_adv = 1'b1;
        end
      end
      RD_ERR: begin
        // aw_done doubles as the "AR accepted" flag for a failed read.
        if (!aw_done_q && m_arvalid[gnt_m_q]) aw_done_d = 1'b1;
        if (aw_done_q && m_rready[gnt_m_q]) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          arb_adv   = 1'b1;
        end
      end
      WR_ERR: begin
        if (!aw_done_q && m_awvalid[gnt_m_q]) aw_done_d = 1'b1;
        if (!w_done_q && m_wvalid[gnt_m_q])   w_done_d  = 1'b1;
        if (aw_done_q && w_done_q && m_bready[gnt_m_q]) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          arb_adv   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing: everything defaults to 0; only the granted pair is connected.
  always_comb begin
    m_arready  = '0;
    m_rdata_o  = '0;
    m_rresp_o  = '0;
    m_rvalid   = '0;
    m_awready  = '0;
    m_wready   = '0;
    m_bresp_o  = '0;
    m_bvalid   = '0;
    s_araddr_o = '0;
    s_arvalid  = '0;
    s_rready   = '0;
    s_awaddr_o = '0;
    s_awvalid  = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    s_wvalid   = '0;
    s_bready   = '0;
    case (state_q)
      RD: begin
        s_araddr_o[gnt_s_q] = m_araddr_v[gnt_m_q];
        s_arvalid[gnt_s_q]  = m_arvalid[gnt_m_q];
        m_arready[gnt_m_q]  = s_arready[gnt_s_q];
        m_rdata_o[gnt_m_q]  = s_rdata_v[gnt_s_q];
        m_rresp_o[gnt_m_q]  = s_rresp_v[gnt_s_q];
        m_rvalid[gnt_m_q]   = s_rvalid[gnt_s_q];
        s_rready[gnt_s_q]   = m_rready[gnt_m_q];
      end
      WR: begin
        s_awaddr_o[gnt_s_q] = m_awaddr_v[gnt_m_q];
        s_awvalid[gnt_s_q]  = m_awvalid[gnt_m_q];
        m_awready[gnt_m_q]  = s_awready[gnt_s_q];
        s_wdata_o[gnt_s_q]  = m_wdata_v[gnt_m_q];
        s_wstrb_o[gnt_s_q]  = m_wstrb_v[gnt_m_q];
        s_wvalid[gnt_s_q]   = m_wvalid[gnt_m_q];
        m_wready[gnt_m_q]   = s_wready[gnt_s_q];
        m_bresp_o[gnt_m_q]  = s_bresp_v[gnt_s_q];
        m_bvalid[gnt_m_q]   = s_bvalid[gnt_s_q];
        s_bready[gnt_s_q]   = m_bready[gnt_m_q];
      end
      RD_ERR: begin
        m_arready[gnt_m_q] = ~aw_done_q;
        m_rvalid[gnt_m_q]  = aw_done_q;
        m_rresp_o[gnt_m_q] = aw_done_q ? RESP_DECERR : RESP_OKAY;
      end
      WR_ERR: begin
        m_awready[gnt_m_q] = ~aw_done_q;
        m_wready[gnt_m_q]  = ~w_done_q;
        m_bvalid[gnt_m_q]  = aw_done_q & w_done_q;
        m_bresp_o[gnt_m_q] = (aw_done_q & w_done_q) ? RESP_DECERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ysyx_25010008_axil_xbar.md
# ysyx_25010008_axil_xbar

Parametrised AXI4-Lite crossbar connecting NUM_M bus masters (IFU, LSU, later DMA) to NUM_S memory-mapped slaves (SRAM, UART, CLINT, …). One transaction in flight system-wide. Grants are chosen by arbitration, and the slave is selected by a parameterised address map. Unmapped addresses complete with DECERR instead of stopping simulation. Sits between the core's bus masters and the slave instances, which are instantiated outside this block.

## Interface
- NUM_M, 2: number of master ports (1..8)
- NUM_S, 2: number of slave ports (1..8)
- AW, 32: address width
- DW, 32: data width; strobe width is DW/8
- S_BASE, {32'h1000_0000, 32'h8000_0000}: packed NUM_S×AW base addresses, slave 0 in the low bits
- S_MASK, {32'hFFFF_F000, 32'hFF00_0000}: packed NUM_S×AW match masks
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- m_araddr / m_arvalid / m_arready: master-side AR channel; in, in, out; widths NUM_M×AW, NUM_M, NUM_M
- m_rdata / m_rresp / m_rvalid / m_rready: master-side R channel; out, out, out, in; widths NUM_M×DW, NUM_M×2, NUM_M, NUM_M
- m_awaddr / m_awvalid / m_awready: master-side AW channel; in, in, out; widths NUM_M×AW, NUM_M, NUM_M
- m_wdata / m_wstrb / m_wvalid / m_wready: master-side W channel; in, in, in, out; widths NUM_M×DW, NUM_M×DW/8, NUM_M, NUM_M
- m_bresp / m_bvalid / m_bready: master-side B channel; out, out, in; widths NUM_M×2, NUM_M, NUM_M
- s_*: slave-side mirror of every m_* channel, NUM_S wide, with directions reversed

## Operation
- States: IDLE, RD, WR, RD_ERR, WR_ERR. Registers: state, gnt_m (index), gnt_s (index), rr_ptr, aw_done, w_done.
- Requests:
  - Master i requests when m_arvalid[i] or m_awvalid[i] is high.
  - If a master requests both, the read wins; the write is considered in a later arbitration round.
- IDLE:
  - Pick a master, latch gnt_m, and decode that master's address.
  - Decode: slave j matches when (addr & S_MASK[j]) == S_BASE[j]. On overlap, the lowest j wins.
  - Next state: RD or WR on a match; RD_ERR or WR_ERR on no match.
- RD / WR:
  - Only the granted master's AR/R or AW/W/B signals are routed to gnt_s, and vice versa.
  - Every other m_* ready/valid output and every other s_* valid/ready output is 0; the data buses of those ports are 0.
- RD_ERR:
  - m_arready[gnt_m] = 1 until the AR handshake.
  - Then m_rvalid = 1, rresp = 2'b11, rdata = 0, held until rready.
- WR_ERR:
  - Accept AW and W independently, tracked by aw_done and w_done.
  - Then m_bvalid = 1, bresp = 2'b11, held until bready.
- Completion: return to IDLE only on the R handshake (rvalid & rready) or the B handshake (bvalid & bready); rvalid or bvalid alone does not complete.
- rr_ptr advances to gnt_m + 1 (mod NUM_M) on completion.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, aw_done = 0, w_done = 0. Every m_* and s_* output is 0.
- Reset asserted mid-transaction:
  - All outputs drop to 0 asynchronously.
  - The in-flight transaction is abandoned, with no response to the master.
  - Slaves are reset by the same rst.
- Arbitration: one IDLE cycle. A request visible at edge N is routed from cycle N+1. Minimum crossbar overhead is 1 cycle per transaction.
- Pass-through paths are purely combinational muxes selected by the registered gnt_m and gnt_s; there is no added latency inside a transaction.
- Masters must hold valid and address stable until their ready, as AXI requires. A request withdrawn in IDLE is simply not granted.
- A request raised in the same cycle as a completion is not seen until the following IDLE cycle.
- Back-to-back transactions from the same master are allowed, subject to arbitration.

## Configuration
- AXIL_XBAR_RR_EN defined: round-robin arbitration. The search starts at rr_ptr, and the first requester found wins.
- AXIL_XBAR_RR_EN not defined: fixed priority, lowest master index wins. rr_ptr is not implemented.

## Structure
- Shared package axil_pkg holds:
  - Response codes RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11.
  - The xbar state enum.
- Sub-module ysyx_25010008_xbar_arb (request vector in, one-hot grant plus index out, rr_ptr inside) isolates the AXIL_XBAR_RR_EN variant.
- Address decode is a generate loop in the top level.

## Test plan
- Routing: master 0 reads 0x8000_0010 while SRAM returns 0xDEADBEEF.
  - Required: m_rdata[0] = 0xDEADBEEF with resp 00.
  - Required: UART s_arvalid stays 0 throughout.
- Write pass-through: master 1 writes 0x1000_0000, wdata 0x41, wstrb 4'b0001.
  - Required: the UART sees the same values.
  - Required: m_bvalid[1] is asserted.
  - Required: master 0 readys stay 0.
- Decode error: master 0 reads 0x2000_0000.
  - Required: rvalid with rresp = 2'b11 and rdata = 0.
  - Required: no s_arvalid asserted.
  - Required: a subsequent valid read succeeds.
- Contention: both masters issue arvalid continuously for 4 transactions.
  - With RR_EN: grants alternate 0, 1, 0, 1.
  - Without RR_EN: all four grants go to master 0.
- Back-pressure: the granted master holds rready = 0 for 5 cycles after rvalid.
  - Required: the state stays RD and no new grant is made.
  - Required: IDLE is reached the cycle after rready = 1.
- Reset: rst is pulled low in the middle of a WR transaction (after AW, before W).
  - Required: all outputs are 0 immediately.
  - Required: after release, a fresh read completes normally.
